tx_tlp_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter sharing the single PCIe Tx local-link between two TLP sources:
//  s0 = posted memory-write engine (rx packets to huge pages, MSI writes), s1 = completion engine
//  (BAR register/MDIO read completions). Sits between the sources and the endpoint trn_t* port.

---
 rtl/tx_tlp_arbiter_if.sv | 28 ++
 rtl/tx_tlp_arbiter.sv | 138 +++++++++++++
 tb/tb_tx_tlp_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_tlp_arbiter_if.sv
// Transmit local-link channel (trn_t* style): data, remainder, framing and the two ready strobes.
// master drives the beat and samples tdst_rdy_n; slave receives the beat and drives tdst_rdy_n.
interface tx_tlp_arbiter_if;
  logic [63:0] td;
  logic [7:0]  trem_n;
  logic        tsof_n;
  logic        teof_n;
  logic        tsrc_rdy_n;
  logic        tdst_rdy_n;

  modport master (
    output td,
    output trem_n,
    output tsof_n,
    output teof_n,
    output tsrc_rdy_n,
    input  tdst_rdy_n
  );

  modport slave (
    input  td,
    input  trem_n,
    input  tsof_n,
    input  teof_n,
    input  tsrc_rdy_n,
    output tdst_rdy_n
  );
endinterface

// File: rtl/tx_tlp_arbiter.sv
// Packet-granular round-robin arbiter sharing the PCIe Tx local-link between two TLP sources.
// Define TX_ARB_STATS_EN to add per-source forwarded-packet counters (s0_pkt_cnt, s1_pkt_cnt).
module tx_tlp_arbiter #(
  parameter int unsigned S0_BUF_BIT = 1,
  parameter int unsigned S1_BUF_BIT = 2,
  parameter int unsigned STAT_W     = 32
) (
  input  logic                  trn_clk,
  input  logic                  trn_reset_n,
  input  logic                  trn_lnk_up_n,
  tx_tlp_arbiter_if.slave       s0,
  tx_tlp_arbiter_if.slave       s1,
  tx_tlp_arbiter_if.master      trn,
`ifdef TX_ARB_STATS_EN
  output logic [STAT_W-1:0]     s0_pkt_cnt,
  output logic [STAT_W-1:0]     s1_pkt_cnt,
`endif
  input  logic [3:0]            trn_tbuf_av
);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e state_q, state_d;
  logic   last_gnt_q, last_gnt_d;
  logic   rst;
  logic   cand0, cand1;
  logic   xfer0, xfer1;
  logic   eof0, eof1;
  logic   unused_tbuf;

  // Link-down behaves exactly like reset.
  assign rst = !trn_reset_n || trn_lnk_up_n;

  assign unused_tbuf = ^trn_tbuf_av;

  // Only a start-of-frame beat with buffer space can win; stray mid-packet beats are ignored.
  assign cand0 = !s0.tsrc_rdy_n && !s0.tsof_n && trn_tbuf_av[S0_BUF_BIT];
  assign cand1 = !s1.tsrc_rdy_n && !s1.tsof_n && trn_tbuf_av[S1_BUF_BIT];

  assign xfer0 = (state_q == StGnt0) && !s0.tsrc_rdy_n && !trn.tdst_rdy_n;
  assign xfer1 = (state_q == StGnt1) && !s1.tsrc_rdy_n && !trn.tdst_rdy_n;
  assign eof0  = xfer0 && !s0.teof_n;
  assign eof1  = xfer1 && !s1.teof_n;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    unique case (state_q)
      StIdle: begin
        if (cand0 && cand1) begin
          state_d = last_gnt_q ? StGnt0 : StGnt1;
        end else if (cand0) begin
          state_d = StGnt0;
        end else if (cand1) begin
          state_d = StGnt1;
        end
      end
      StGnt0: begin
        if (eof0) begin
          state_d    = StIdle;
          last_gnt_d = 1'b0;
        end
      end
      StGnt1: begin
        if (eof1) begin
          state_d    = StIdle;
          last_gnt_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge trn_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    trn.td         = '0;
    trn.trem_n     = '0;
    trn.tsof_n     = 1'b1;
    trn.teof_n     = 1'b1;
    trn.tsrc_rdy_n = 1'b1;
    s0.tdst_rdy_n  = 1'b1;
    s1.tdst_rdy_n  = 1'b1;
    unique case (state_q)
      StGnt0: begin
        trn.td         = s0.td;
        trn.trem_n     = s0.trem_n;
        trn.tsof_n     = s0.tsof_n;
        trn.teof_n     = s0.teof_n;
        trn.tsrc_rdy_n = s0.tsrc_rdy_n;
        s0.tdst_rdy_n  = trn.tdst_rdy_n;
      end
      StGnt1: begin
        trn.td         = s1.td;
        trn.trem_n     = s1.trem_n;
        trn.tsof_n     = s1.tsof_n;
        trn.teof_n     = s1.teof_n;
        trn.tsrc_rdy_n = s1.tsrc_rdy_n;
        s1.tdst_rdy_n  = trn.tdst_rdy_n;
      end
      default: ;
    endcase
  end

`ifdef TX_ARB_STATS_EN
  logic [STAT_W-1:0] s0_cnt_q, s0_cnt_d;
  logic [STAT_W-1:0] s1_cnt_q, s1_cnt_d;

  always_comb begin
    s0_cnt_d = eof0 ? s0_cnt_q + 1'b1 : s0_cnt_q;
    s1_cnt_d = eof1 ? s1_cnt_q + 1'b1 : s1_cnt_q;
  end

  always_ff @(posedge trn_clk) begin
    if (rst) begin
      s0_cnt_q <= '0;
      s1_cnt_q <= '0;
    end else begin
      s0_cnt_q <= s0_cnt_d;
      s1_cnt_q <= s1_cnt_d;
    end
  end

  assign s0_pkt_cnt = s0_cnt_q;
  assign s1_pkt_cnt = s1_cnt_q;
`else
  localparam int unsigned unused_stat_w = STAT_W;
`endif

endmodule

// File: tb/tb_tx_tlp_arbiter.sv
// Scoreboard bench for tx_tlp_arbiter: packet queues per source, a packet-level round-robin
// model deciding ownership, and a negedge monitor comparing every forwarded beat.
module tb_tx_tlp_arbiter;

  typedef struct packed {
    logic [63:0] td;
    logic [7:0]  rem;
    logic        sof;
    logic        eof;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lnk_up_n;
  logic [3:0] tbuf_av;
  logic       core_rdy_n;

  always #5 clk = ~clk;

  tx_tlp_arbiter_if s0_if ();
  tx_tlp_arbiter_if s1_if ();
  tx_tlp_arbiter_if trn_if ();

  logic [63:0] s_td        [2];
  logic [7:0]  s_rem       [2];
  logic        s_sof_n     [2];
  logic        s_eof_n     [2];
  logic        s_src_rdy_n [2];
  logic        s_dst_rdy_n [2];

  assign s0_if.td         = s_td[0];
  assign s0_if.trem_n     = s_rem[0];
  assign s0_if.tsof_n     = s_sof_n[0];
  assign s0_if.teof_n     = s_eof_n[0];
  assign s0_if.tsrc_rdy_n = s_src_rdy_n[0];
  assign s1_if.td         = s_td[1];
  assign s1_if.trem_n     = s_rem[1];
  assign s1_if.tsof_n     = s_sof_n[1];
  assign s1_if.teof_n     = s_eof_n[1];
  assign s1_if.tsrc_rdy_n = s_src_rdy_n[1];
  assign s_dst_rdy_n[0]   = s0_if.tdst_rdy_n;
  assign s_dst_rdy_n[1]   = s1_if.tdst_rdy_n;
  assign trn_if.tdst_rdy_n = core_rdy_n;

`ifdef TX_ARB_STATS_EN
  logic [31:0] s0_cnt;
  logic [31:0] s1_cnt;
`endif

  tx_tlp_arbiter #(
    .S0_BUF_BIT (1),
    .S1_BUF_BIT (2),
    .STAT_W     (32)
  ) dut (
    .trn_clk      (clk),
    .trn_reset_n  (rst_n),
    .trn_lnk_up_n (lnk_up_n),
    .s0           (s0_if),
    .s1           (s1_if),
    .trn          (trn_if),
`ifdef TX_ARB_STATS_EN
    .s0_pkt_cnt   (s0_cnt),
    .s1_pkt_cnt   (s1_cnt),
`endif
    .trn_tbuf_av  (tbuf_av)
  );

  beat_t stim0[$];
  beat_t stim1[$];
  beat_t exp0[$];
  beat_t exp1[$];
  beat_t mon_e;

  int total = 0;
  int bad   = 0;
  int mown  = -1;
  int mlast = 1;
  int cnt_m [2];
  int beats_acc [2];
  logic acc [2];
  logic stall_en;
  logic force_stall [2];
  logic cand [2];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic gen_pkt(input int n, input int len);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.td         = {$urandom, $urandom};
      b.td[63:56]  = (n == 0) ? 8'h50 : 8'h51;
      b.rem        = (i == len - 1 && $urandom_range(0, 1) == 1) ? 8'h0F : 8'h00;
      b.sof        = (i == 0);
      b.eof        = (i == len - 1);
      if (n == 0) begin
        stim0.push_back(b);
        exp0.push_back(b);
      end else begin
        stim1.push_back(b);
        exp1.push_back(b);
      end
    end
  endtask

  // Source drivers: advance one beat per accepted handshake, optional random stalls.
  always @(posedge clk) begin
    #1;
    for (int n = 0; n < 2; n++) begin
      beat_t h;
      logic  has;
      logic  stall;
      if (acc[n]) begin
        if (n == 0 && stim0.size() > 0) void'(stim0.pop_front());
        if (n == 1 && stim1.size() > 0) void'(stim1.pop_front());
        beats_acc[n]++;
      end
      has   = (n == 0) ? (stim0.size() > 0) : (stim1.size() > 0);
      h     = '0;
      if (has) h = (n == 0) ? stim0[0] : stim1[0];
      stall = force_stall[n] || (stall_en && $urandom_range(0, 4) == 0);
      if (has && !stall) begin
        s_td[n]        = h.td;
        s_rem[n]       = h.rem;
        s_sof_n[n]     = !h.sof;
        s_eof_n[n]     = !h.eof;
        s_src_rdy_n[n] = 1'b0;
      end else begin
        s_td[n]        = '0;
        s_rem[n]       = '0;
        s_sof_n[n]     = 1'b1;
        s_eof_n[n]     = 1'b1;
        s_src_rdy_n[n] = 1'b1;
      end
    end
  end

  // Monitor and reference model: ownership decided per packet from the arbitration rules.
  always @(negedge clk) begin
    int o;
    if (!rst_n || lnk_up_n) begin
      if (mown < 0) begin
        chk("reset_outputs", {trn_if.td, trn_if.trem_n, trn_if.tsof_n, trn_if.teof_n,
            trn_if.tsrc_rdy_n, s_dst_rdy_n[0], s_dst_rdy_n[1]}, {64'h0, 8'h0, 5'h1f});
      end
      mown     = -1;
      mlast    = 1;
      cnt_m[0] = 0;
      cnt_m[1] = 0;
      acc[0]   = 1'b0;
      acc[1]   = 1'b0;
    end else begin
      for (int n = 0; n < 2; n++) acc[n] = !s_src_rdy_n[n] && !s_dst_rdy_n[n];
      if (mown < 0) begin
        chk("idle_outputs", {trn_if.td, trn_if.trem_n, trn_if.tsof_n, trn_if.teof_n,
            trn_if.tsrc_rdy_n, s_dst_rdy_n[0], s_dst_rdy_n[1]}, {64'h0, 8'h0, 5'h1f});
        cand[0] = !s_src_rdy_n[0] && !s_sof_n[0] && tbuf_av[1];
        cand[1] = !s_src_rdy_n[1] && !s_sof_n[1] && tbuf_av[2];
        if (cand[0] && cand[1]) mown = (mlast == 0) ? 1 : 0;
        else if (cand[0])       mown = 0;
        else if (cand[1])       mown = 1;
      end else begin
        o = 1 - mown;
        chk("other_dst_rdy", s_dst_rdy_n[o], 1'b1);
        chk("own_dst_rdy", s_dst_rdy_n[mown], core_rdy_n);
        chk("src_rdy_mux", trn_if.tsrc_rdy_n, s_src_rdy_n[mown]);
        if (!s_src_rdy_n[mown] && !core_rdy_n) begin
          chk("beat_expected", (mown == 0) ? (exp0.size() != 0) : (exp1.size() != 0), 1'b1);
          if (mown == 0 && exp0.size() != 0) mon_e = exp0.pop_front();
          else if (mown == 1 && exp1.size() != 0) mon_e = exp1.pop_front();
          chk("beat_data", {trn_if.td, trn_if.trem_n, trn_if.tsof_n, trn_if.teof_n},
              {mon_e.td, mon_e.rem, !mon_e.sof, !mon_e.eof});
          if (mon_e.eof) begin
            cnt_m[mown]++;
            mlast = mown;
            mown  = -1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && cyc < 3000) begin
      tick();
      cyc++;
    end
    chk(name, cyc < 3000, 1'b1);
    repeat (2) tick();
  endtask

  // Leave last_gnt at 0, then cut an s1 packet after two beats with reset or link-down.
  task automatic pulse_reset(input bit use_link);
    int start;
    int cyc = 0;
    gen_pkt(0, 2);
    drain("pre_reset_drain");
    start = beats_acc[1];
    gen_pkt(1, 5);
    while (beats_acc[1] < start + 2 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("reset_wait", cyc < 100, 1'b1);
    if (use_link) lnk_up_n = 1'b1;
    else          rst_n    = 1'b0;
    stim0.delete();
    stim1.delete();
    exp0.delete();
    exp1.delete();
    for (int n = 0; n < 2; n++) begin
      s_src_rdy_n[n] = 1'b1;
      s_sof_n[n]     = 1'b1;
      s_eof_n[n]     = 1'b1;
    end
    tick();
    rst_n    = 1'b1;
    lnk_up_n = 1'b0;
    gen_pkt(1, 2);
    gen_pkt(0, 2);
    drain("post_reset_drain");
  endtask

  initial begin
    rst_n          = 1'b0;
    lnk_up_n       = 1'b0;
    tbuf_av        = 4'hF;
    core_rdy_n     = 1'b0;
    stall_en       = 1'b0;
    force_stall[0] = 1'b0;
    force_stall[1] = 1'b0;
    acc[0]         = 1'b0;
    acc[1]         = 1'b0;
    beats_acc[0]   = 0;
    beats_acc[1]   = 0;
    cnt_m[0]       = 0;
    cnt_m[1]       = 0;
    for (int n = 0; n < 2; n++) begin
      s_td[n]        = '0;
      s_rem[n]       = '0;
      s_sof_n[n]     = 1'b1;
      s_eof_n[n]     = 1'b1;
      s_src_rdy_n[n] = 1'b1;
    end
    repeat (3) tick();
    rst_n = 1'b1;

    gen_pkt(0, 4);
    drain("single_s0_pkt");

    repeat (3) begin
      gen_pkt(0, 3);
      gen_pkt(1, 2);
      drain("rr_pair");
    end

    tbuf_av = 4'b1101;
    gen_pkt(0, 3);
    gen_pkt(1, 5);
    repeat (4) tick();
    tbuf_av = 4'hF;
    drain("tbuf_gate");

    gen_pkt(0, 8);
    gen_pkt(1, 3);
    repeat (3) tick();
    core_rdy_n = 1'b1;
    repeat (3) tick();
    core_rdy_n = 1'b0;
    tick();
    force_stall[0] = 1'b1;
    repeat (2) tick();
    force_stall[0] = 1'b0;
    drain("backpressure_stall");

    pulse_reset(1'b0);
    pulse_reset(1'b1);

    stall_en = 1'b1;
    repeat (400) begin
      tick();
      tbuf_av    = 4'($urandom);
      tbuf_av[1] = $urandom_range(0, 3) != 0;
      tbuf_av[2] = $urandom_range(0, 3) != 0;
      core_rdy_n = $urandom_range(0, 3) == 0;
      if (exp0.size() < 12 && $urandom_range(0, 5) == 0) gen_pkt(0, $urandom_range(1, 6));
      if (exp1.size() < 12 && $urandom_range(0, 5) == 0) gen_pkt(1, $urandom_range(1, 6));
    end
    stall_en   = 1'b0;
    tbuf_av    = 4'hF;
    core_rdy_n = 1'b0;
    drain("random_drain");

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) gen_pkt(0, (i % 4) + 1);
    for (int i = 0; i < 7; i++) gen_pkt(1, (i % 3) + 1);
    drain("count_drain");
`ifdef TX_ARB_STATS_EN
    chk("s0_pkt_cnt", s0_cnt, 32'(cnt_m[0]));
    chk("s1_pkt_cnt", s1_cnt, 32'(cnt_m[1]));
    chk("s0_pkt_cnt_abs", s0_cnt, 32'd10);
    chk("s1_pkt_cnt_abs", s1_cnt, 32'd7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
